// File: rtl/mem_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_ctrl
// Brief    : eLC-3 memory/I-O controller running multi-cycle asynchronous SRAM
//            reads/writes. Define MMIO_EN to decode the keyboard/display
//            registers at xFE00-xFFFF instead of sending them to the SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module mem_io_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] Addr,
    input  logic [15:0] Data_From_CPU,
    output logic [15:0] Data_To_CPU,
    output logic        R,
    output logic [15:0] SRAM_ADDR,
    input  logic [15:0] SRAM_DQ_IN,
    output logic [15:0] SRAM_DQ_OUT,
    output logic        SRAM_DQ_OE,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    input  logic [7:0]  KB_Data,
    input  logic        KB_Strobe,
    output logic [7:0]  DDR_Data,
    output logic        DDR_Strobe
);

    localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wait_cnt;
    logic        r_rw;
    logic [15:0] r_sram_addr;
    logic [15:0] r_sram_dq_out;
    logic [15:0] r_data_to_cpu;

    logic        w_accept;
    logic        w_is_io;
    logic [15:0] w_io_rdata;
    logic        w_capture_sram;
    logic        w_capture_io;

    assign w_accept       = (r_state == ST_IDLE) && MIO_EN;
    assign w_capture_sram = (r_state == ST_ACCESS) && (r_wait_cnt == 4'd0) && !r_rw;
    assign w_capture_io   = w_accept && w_is_io && !R_W;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and SRAM strobes; strobes decode only from registered
    // state so they cannot glitch with the request inputs.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        SRAM_CE_N   = 1'b1;
        SRAM_OE_N   = 1'b1;
        SRAM_WE_N   = 1'b1;
        SRAM_DQ_OE  = 1'b0;
        R           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (MIO_EN) begin
                    w_state_nxt = w_is_io ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                SRAM_CE_N = 1'b0;
                if (r_rw) begin
                    SRAM_WE_N  = 1'b0;
                    SRAM_DQ_OE = 1'b1;
                end else begin
                    SRAM_OE_N  = 1'b0;
                end
                if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                R           = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, wait counter and read-data register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wait_cnt    <= 4'd0;
            r_rw          <= 1'b0;
            r_sram_addr   <= 16'h0000;
            r_sram_dq_out <= 16'h0000;
            r_data_to_cpu <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_rw <= R_W;
                // I/O requests leave the SRAM bus untouched
                if (!w_is_io) begin
                    r_sram_addr   <= Addr;
                    r_sram_dq_out <= Data_From_CPU;
                    r_wait_cnt    <= c_WAIT_INIT;
                end
            end else if ((r_state == ST_ACCESS) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end

            if (w_capture_sram) begin
                r_data_to_cpu <= SRAM_DQ_IN;
            end else if (w_capture_io) begin
                r_data_to_cpu <= w_io_rdata;
            end
        end
    end

    assign Data_To_CPU = r_data_to_cpu;
    assign SRAM_ADDR   = r_sram_addr;
    assign SRAM_DQ_OUT = r_sram_dq_out;

`ifdef MMIO_EN
    localparam logic [15:0] c_ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] c_ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] c_ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] c_ADDR_DDR  = 16'hFE06;

    logic       r_kb_ready;
    logic [7:0] r_kb_char;
    logic [7:0] r_ddr_data;
    logic       r_ddr_wr;
    logic       w_kbdr_read;
    logic       w_ddr_write;

    assign w_is_io     = &Addr[15:9];
    assign w_kbdr_read = w_accept && !R_W && (Addr == c_ADDR_KBDR);
    assign w_ddr_write = w_accept && R_W && (Addr == c_ADDR_DDR);

    // I/O read data is resolved at acceptance because DONE follows directly
    always_comb begin
        w_io_rdata = 16'h0000;
        case (Addr)
            c_ADDR_KBSR: w_io_rdata = {r_kb_ready, 15'b0};
            c_ADDR_KBDR: w_io_rdata = {8'h00, r_kb_char};
            c_ADDR_DSR:  w_io_rdata = 16'h8000;
            default:     w_io_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_kb_ready <= 1'b0;
            r_kb_char  <= 8'h00;
            r_ddr_data <= 8'h00;
            r_ddr_wr   <= 1'b0;
        end else begin
            // a new keystroke overrides the clear from a coincident KBDR read
            if (KB_Strobe) begin
                r_kb_ready <= 1'b1;
                r_kb_char  <= KB_Data;
            end else if (w_kbdr_read) begin
                r_kb_ready <= 1'b0;
            end
            if (w_accept) begin
                r_ddr_wr <= w_ddr_write;
            end
            if (w_ddr_write) begin
                r_ddr_data <= Data_From_CPU[7:0];
            end
        end
    end

    assign DDR_Data   = r_ddr_data;
    assign DDR_Strobe = (r_state == ST_DONE) && r_ddr_wr;
`else
    logic w_unused_kb;

    assign w_is_io     = 1'b0;
    assign w_io_rdata  = 16'h0000;
    assign w_unused_kb = ^{KB_Data, KB_Strobe};
    assign DDR_Data    = 8'h00;
    assign DDR_Strobe  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_io_ctrl
// Brief    : Self-checking bench for mem_io_ctrl against a transaction-level
//            memory/I-O model; honours MMIO_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_io_ctrl;

    localparam int c_WAIT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        mio_en, mio_en0, r_w, kb_strobe;
    logic [15:0] addr, din;
    logic [7:0]  kb_data;

    logic [15:0] dout, sram_addr, dq_out;
    logic [15:0] dq_in = 16'hDEAD;
    logic        r, dq_oe, ce_n, oe_n, we_n, ddr_strobe;
    logic [7:0]  ddr_data;

    logic [15:0] dout0, sram_addr0, dq_out0, dq_in0;
    logic        r0, dq_oe0, ce_n0, oe_n0, we_n0, ddr_strobe0;
    logic [7:0]  ddr_data0;

    int n_cmp = 0;
    int n_err = 0;

    // transaction-level reference state
    logic [15:0] ref_mem [int];
    logic [15:0] exp_dout = 16'h0000;
    bit          kb_ready = 1'b0;
    logic [7:0]  kb_char = 8'h00;
    logic [7:0]  exp_ddr_data = 8'h00;

    logic [15:0] sram_mem [int];

    always #5 clk = ~clk;

    assign dq_in0 = 16'h5A5A;

    mem_io_ctrl #(.WAIT_CYCLES(c_WAIT)) u_dut (
        .Clk(clk), .Reset(rst), .MIO_EN(mio_en), .R_W(r_w), .Addr(addr),
        .Data_From_CPU(din), .Data_To_CPU(dout), .R(r), .SRAM_ADDR(sram_addr),
        .SRAM_DQ_IN(dq_in), .SRAM_DQ_OUT(dq_out), .SRAM_DQ_OE(dq_oe),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
        .KB_Data(kb_data), .KB_Strobe(kb_strobe), .DDR_Data(ddr_data),
        .DDR_Strobe(ddr_strobe)
    );

    mem_io_ctrl #(.WAIT_CYCLES(0)) u_dut_w0 (
        .Clk(clk), .Reset(rst), .MIO_EN(mio_en0), .R_W(r_w), .Addr(addr),
        .Data_From_CPU(din), .Data_To_CPU(dout0), .R(r0), .SRAM_ADDR(sram_addr0),
        .SRAM_DQ_IN(dq_in0), .SRAM_DQ_OUT(dq_out0), .SRAM_DQ_OE(dq_oe0),
        .SRAM_CE_N(ce_n0), .SRAM_OE_N(oe_n0), .SRAM_WE_N(we_n0),
        .KB_Data(kb_data), .KB_Strobe(kb_strobe), .DDR_Data(ddr_data0),
        .DDR_Strobe(ddr_strobe0)
    );

    // Asynchronous SRAM: never-written words read back as addr ^ xA5C3
    always @(posedge clk) begin
        #1;
        if (!ce_n && !we_n && dq_oe) sram_mem[int'(sram_addr)] = dq_out;
        if (!ce_n && !oe_n)
            dq_in <= sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)]
                                                      : (sram_addr ^ 16'hA5C3);
        else
            dq_in <= 16'hDEAD;
    end

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return a ^ 16'hA5C3;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_access(input bit rw, input logic [15:0] a, input logic [15:0] wd,
                             input bit kb_pulse, input logic [7:0] kb_ch);
        bit          io;
        bit          exp_ddr;
        int          exp_lat, exp_strb;
        int          lat, ce_cyc, dir_cyc, ddr_cyc;
        bit          ddr_at_r;
        io       = 1'b0;
`ifdef MMIO_EN
        io       = (a >= 16'hFE00);
`endif
        exp_ddr  = 1'b0;
        if (io) begin
            exp_lat  = 1;
            exp_strb = 0;
            if (!rw) begin
                case (a)
                    16'hFE00: exp_dout = {kb_ready, 15'b0};
                    16'hFE02: begin exp_dout = {8'h00, kb_char}; kb_ready = 1'b0; end
                    16'hFE04: exp_dout = 16'h8000;
                    default:  exp_dout = 16'h0000;
                endcase
            end else if (a == 16'hFE06) begin
                exp_ddr      = 1'b1;
                exp_ddr_data = wd[7:0];
            end
        end else begin
            exp_lat  = c_WAIT + 2;
            exp_strb = c_WAIT + 1;
            if (rw) ref_mem[int'(a)] = wd;
            else    exp_dout = ref_rd(a);
        end
        if (kb_pulse) begin
            kb_ready = 1'b1;
            kb_char  = kb_ch;
        end

        @(negedge clk);
        mio_en = 1'b1; r_w = rw; addr = a; din = wd;
        kb_strobe = kb_pulse; kb_data = kb_ch;
        lat = 0; ce_cyc = 0; dir_cyc = 0; ddr_cyc = 0; ddr_at_r = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            mio_en = 1'b0; kb_strobe = 1'b0;
            if (!ce_n) begin
                ce_cyc++;
                if (rw ? (!we_n && oe_n && dq_oe) : (!oe_n && we_n && !dq_oe)) dir_cyc++;
            end
            if (ddr_strobe) ddr_cyc++;
            if (r) begin
                lat      = i;
                ddr_at_r = ddr_strobe;
                break;
            end
        end
        check_val("latency", lat, exp_lat);
        check_val("ce_cycles", ce_cyc, exp_strb);
        check_val("dir_cycles", dir_cyc, exp_strb);
        check_val("data_to_cpu", dout, exp_dout);
        check_val("ddr_strobe_at_r", ddr_at_r, exp_ddr);
        check_val("ddr_strobe_count", ddr_cyc, exp_ddr);
        check_val("ddr_data", ddr_data, exp_ddr_data);
        if (!io) begin
            check_val("sram_addr", sram_addr, a);
            if (rw) check_val("sram_dq_out", dq_out, wd);
        end
        @(negedge clk);
        check_val("r_single_pulse", r, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n;
        int          rpos [4];
        int          rcount;
        logic [15:0] a;

        rst = 1'b1; mio_en = 1'b0; mio_en0 = 1'b0; r_w = 1'b0;
        addr = 16'h0000; din = 16'h0000; kb_strobe = 1'b0; kb_data = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_r", r, 1'b0);
        check_val("rst_ce_n", ce_n, 1'b1);
        check_val("rst_dout", dout, 16'h0000);
        check_val("rst_sram_addr", sram_addr, 16'h0000);
        check_val("rst_dq_out", dq_out, 16'h0000);
        check_val("rst_ddr", {ddr_strobe, ddr_data}, 9'h000);
        check_val("rst_r_w0", r0, 1'b0);
        rst = 1'b0;

        // directed SRAM accesses
        do_access(1'b1, 16'h3000, 16'h1234, 1'b0, 8'h00);
        do_access(1'b0, 16'h3000, 16'h0000, 1'b0, 8'h00);
        do_access(1'b1, 16'h4000, 16'hBEEF, 1'b0, 8'h00);
        do_access(1'b0, 16'h4000, 16'h0000, 1'b0, 8'h00);

        // back-to-back reads on the zero-wait instance with MIO_EN held
        @(negedge clk);
        r_w = 1'b0; addr = 16'h1000; mio_en0 = 1'b1;
        n = 0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (r0) begin
                if (n < 4) rpos[n] = i;
                n++;
            end
        end
        mio_en0 = 1'b0;
        check_val("b2b_count", n, 4);
        for (int k = 0; k < 4; k++)
            check_val("b2b_pos", (k < n) ? rpos[k] : 0, 2 + 3 * k);
        check_val("b2b_data", dout0, 16'h5A5A);
        repeat (2) @(negedge clk);

        // keyboard / display registers (plain SRAM words when not decoded)
        @(negedge clk);
        kb_strobe = 1'b1; kb_data = 8'h41;
        @(negedge clk);
        kb_strobe = 1'b0;
`ifdef MMIO_EN
        kb_ready = 1'b1; kb_char = 8'h41;
`endif
        do_access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);
        do_access(1'b0, 16'hFE02, 16'h0000, 1'b0, 8'h00);
        do_access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);
        do_access(1'b1, 16'hFE06, 16'h0048, 1'b0, 8'h00);
        do_access(1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00);
        do_access(1'b0, 16'hFE00, 16'h0000, 1'b1, 8'h41);
        do_access(1'b0, 16'hFE02, 16'h0000, 1'b1, 8'h5A);
        do_access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);
        do_access(1'b0, 16'hFE02, 16'h0000, 1'b0, 8'h00);

        // randomized mix of SRAM and I/O-region accesses
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 3) == 0) a = 16'hFE00 + 16'(2 * $urandom_range(0, 5));
            else                           a = 16'h0100 + 16'($urandom_range(0, 31));
            do_access(1'($urandom_range(0, 1)), a, 16'($urandom),
                      ($urandom_range(0, 7) == 0), 8'($urandom));
        end

        // reset in the middle of an SRAM read
        @(negedge clk);
        mio_en = 1'b1; r_w = 1'b0; addr = 16'h2222;
        @(negedge clk);
        mio_en = 1'b0;
        check_val("mid_ce_active", ce_n, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_strobes", {ce_n, oe_n, we_n, dq_oe}, 4'b1110);
        check_val("mid_rst_r", r, 1'b0);
        check_val("mid_rst_dout", dout, 16'h0000);
        check_val("mid_rst_sram_addr", sram_addr, 16'h0000);
        check_val("mid_rst_ddr", {ddr_strobe, ddr_data}, 9'h000);
        exp_dout = 16'h0000; kb_ready = 1'b0; exp_ddr_data = 8'h00;
        rcount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (r) rcount++;
        end
        check_val("mid_rst_no_r", rcount, 0);
        do_access(1'b0, 16'h2222, 16'h0000, 1'b0, 8'h00);
        do_access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
